// File: rtl/mpu_fp_arbiter.sv
// Shares one non-pipelined FP operator among NUM_REQ requesters, one operation in flight.
// Build option MPU_ARB_FIXED_PRIORITY_EN: lowest-index requester wins instead of round-robin.
module mpu_fp_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ*32-1:0]  req_a,
  input  logic [NUM_REQ*32-1:0]  req_b,
  input  logic [NUM_REQ-1:0]     req_stb,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [31:0]            rsp_z,
  output logic [NUM_REQ-1:0]     rsp_stb,
  input  logic [NUM_REQ-1:0]     rsp_ack,
  output logic [31:0]            fpu_a,
  output logic [31:0]            fpu_b,
  output logic                   fpu_input_stb,
  input  logic                   fpu_input_ack,
  input  logic [31:0]            fpu_z,
  input  logic                   fpu_output_stb,
  output logic                   fpu_output_ack
);
  localparam int unsigned GW = $clog2(NUM_REQ);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ISSUE  = 2'd1;
  localparam logic [1:0] WAIT   = 2'd2;
  localparam logic [1:0] RETURN = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [31:0]        a_q, a_d, b_q, b_d, z_q, z_d;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [NUM_REQ-1:0] rsp_stb_q, rsp_stb_d;
  logic               in_stb_q, in_stb_d;
  logic               out_ack_q, out_ack_d;

  logic [GW-1:0]      start;
  logic [GW-1:0]      winner, idx;
  logic               found;
  logic [31:0]        a_sel, b_sel;
  logic [NUM_REQ-1:0] win_oh, grant_oh;
  logic               rsp_done;

  assign rsp_done = |(rsp_ack & grant_oh);

`ifdef MPU_ARB_FIXED_PRIORITY_EN
  // Searching from the top index makes the wrap-around search a plain lowest-index pick.
  assign start = GW'(NUM_REQ - 1);
`else
  logic [GW-1:0] last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (state_q == RETURN && rsp_done) last_d = grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_q <= GW'(NUM_REQ - 1);
    else     last_q <= last_d;
  end

  assign start = last_q;
`endif

  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = GW'((32'(start) + k) % NUM_REQ);
      if (!found && req_stb[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    a_sel    = '0;
    b_sel    = '0;
    win_oh   = '0;
    grant_oh = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (winner == GW'(i)) begin
        a_sel     = req_a[32*i +: 32];
        b_sel     = req_b[32*i +: 32];
        win_oh[i] = 1'b1;
      end
      grant_oh[i] = (grant_q == GW'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    a_d       = a_q;
    b_d       = b_q;
    z_d       = z_q;
    req_ack_d = '0;
    rsp_stb_d = rsp_stb_q;
    in_stb_d  = in_stb_q;
    out_ack_d = out_ack_q;
    case (state_q)
      IDLE: if (found) begin
        state_d   = ISSUE;
        grant_d   = winner;
        a_d       = a_sel;
        b_d       = b_sel;
        req_ack_d = win_oh;
        in_stb_d  = 1'b1;
      end
      ISSUE: if (fpu_input_ack) begin
        state_d   = WAIT;
        in_stb_d  = 1'b0;
        out_ack_d = 1'b1;
      end
      WAIT: if (fpu_output_stb) begin
        state_d   = RETURN;
        out_ack_d = 1'b0;
        z_d       = fpu_z;
        rsp_stb_d = grant_oh;
      end
      RETURN: if (rsp_done) begin
        state_d   = IDLE;
        rsp_stb_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      a_q       <= '0;
      b_q       <= '0;
      z_q       <= '0;
      req_ack_q <= '0;
      rsp_stb_q <= '0;
      in_stb_q  <= 1'b0;
      out_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      a_q       <= a_d;
      b_q       <= b_d;
      z_q       <= z_d;
      req_ack_q <= req_ack_d;
      rsp_stb_q <= rsp_stb_d;
      in_stb_q  <= in_stb_d;
      out_ack_q <= out_ack_d;
    end
  end

  assign req_ack        = req_ack_q;
  assign rsp_stb        = rsp_stb_q;
  assign rsp_z          = z_q;
  assign fpu_a          = a_q;
  assign fpu_b          = b_q;
  assign fpu_input_stb  = in_stb_q;
  assign fpu_output_ack = out_ack_q;

endmodule
